// File: rtl/e203_exu_fpu_fdiv_ctrl.sv
// e203_exu_fpu_fdiv_ctrl: issue/writeback control for the FDIV.S divider,
// with NaN canonicalisation, fflags generation and a result skid register.
module e203_exu_fpu_fdiv_ctrl #(
    parameter int RD_W  = 5,
    parameter int LAT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_valid,
    output logic             i_ready,
    input  logic [31:0]      i_rs1,
    input  logic [31:0]      i_rs2,
    input  logic [RD_W-1:0]  i_rd,
    input  logic             flush,
    output logic             div_i_valid,
    output logic [31:0]      div_rs1,
    output logic [31:0]      div_rs2,
    input  logic             div_o_valid,
    output logic             div_o_ready,
    input  logic [31:0]      div_wdat,
    output logic             o_valid,
    input  logic             o_ready,
    output logic [31:0]      o_wdat,
    output logic [RD_W-1:0]  o_rd,
    output logic [4:0]       o_fflags,
    output logic [LAT_W-1:0] o_lat,
    output logic             busy
);
    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, RESP} state_e;
    state_e            state_q;
    logic              boot_q, discard_q;
    logic [31:0]       rs1_q, rs2_q, wdat_q;
    logic [RD_W-1:0]   rd_q;
    logic [4:0]        flags_q;
    logic [LAT_W-1:0]  lat_q;
    logic              nv_q, dz_q, of_ok_q, uf_ok_q;
    logic              accept;
    logic              a_fin, b_fin, a_zero, b_zero, a_inf, b_inf, a_snan, b_snan;
    logic              nv_d, dz_d, of_ok_d, uf_ok_d;
    logic              r_nan, r_inf, r_exp0, of, uf;
    logic [4:0]        flags_d;
    logic [31:0]       wdat_d;

    // boot_q keeps i_ready low until the post-reset DRAIN cycle has passed
    assign i_ready     = (state_q == IDLE && boot_q) || (state_q == RESP && o_ready);
    assign accept      = i_valid && i_ready;
    assign div_i_valid = state_q == ISSUE;
    assign div_o_ready = state_q == ISSUE;
    assign o_valid     = state_q == RESP;
    assign busy        = state_q != IDLE;
    assign div_rs1     = rs1_q;
    assign div_rs2     = rs2_q;
    assign o_wdat      = wdat_q;
    assign o_rd        = rd_q;
    assign o_fflags    = flags_q;
    assign o_lat       = lat_q;

    assign a_fin   = i_rs1[30:23] != 8'hFF;
    assign b_fin   = i_rs2[30:23] != 8'hFF;
    assign a_zero  = (i_rs1 << 1) == 32'h0;
    assign b_zero  = (i_rs2 << 1) == 32'h0;
    assign a_inf   = (i_rs1 << 1) == 32'hFF00_0000;
    assign b_inf   = (i_rs2 << 1) == 32'hFF00_0000;
    assign a_snan  = !a_fin && !i_rs1[22] && |i_rs1[21:0];
    assign b_snan  = !b_fin && !i_rs2[22] && |i_rs2[21:0];
    assign nv_d    = a_snan || b_snan || (a_inf && b_inf) || (a_zero && b_zero);
    assign dz_d    = b_zero && a_fin && !a_zero;
    assign of_ok_d = a_fin && b_fin && !b_zero;
    assign uf_ok_d = a_fin && !a_zero && b_fin;

    assign r_nan   = &div_wdat[30:23] && |div_wdat[22:0];
    assign r_inf   = &div_wdat[30:23] && ~|div_wdat[22:0];
    assign r_exp0  = ~|div_wdat[30:23];
    assign of      = r_inf && of_ok_q;
    assign uf      = r_exp0 && uf_ok_q;
    assign flags_d = (nv_q || dz_q) ? {nv_q, dz_q, 3'b000} : {2'b00, of, uf, of || uf};
    assign wdat_d  = r_nan ? 32'h7FC0_0000 : div_wdat;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            boot_q    <= 1'b0;
            discard_q <= 1'b0;
            rs1_q     <= '0;
            rs2_q     <= '0;
            wdat_q    <= '0;
            rd_q      <= '0;
            flags_q   <= '0;
            lat_q     <= '0;
            nv_q      <= 1'b0;
            dz_q      <= 1'b0;
            of_ok_q   <= 1'b0;
            uf_ok_q   <= 1'b0;
        end else begin
            boot_q <= 1'b1;
            case (state_q)
                IDLE:  if (!boot_q) state_q <= DRAIN;
                DRAIN: state_q <= IDLE;
                ISSUE: begin
                    lat_q <= lat_q + LAT_W'(~&lat_q);
                    if (div_o_valid) begin
                        discard_q <= 1'b0;
                        if (flush || discard_q) begin
                            state_q <= IDLE;
                        end else begin
                            wdat_q  <= wdat_d;
                            flags_q <= flags_d;
                            state_q <= RESP;
                        end
                    end else if (flush) begin
                        discard_q <= 1'b1;
                    end
                end
                RESP:  if (o_ready || flush) state_q <= IDLE;
            endcase
            if (accept) begin
                rs1_q     <= i_rs1;
                rs2_q     <= i_rs2;
                rd_q      <= i_rd;
                nv_q      <= nv_d;
                dz_q      <= dz_d;
                of_ok_q   <= of_ok_d;
                uf_ok_q   <= uf_ok_d;
                lat_q     <= '0;
                discard_q <= 1'b0;
                state_q   <= ISSUE;
            end
        end
    end
endmodule

// File: tb/tb_e203_exu_fpu_fdiv_ctrl.sv
// tb_e203_exu_fpu_fdiv_ctrl: directed and random checks of the FDIV controller
// against a divider stub and a result/flag reference model.
module tb_e203_exu_fpu_fdiv_ctrl;
    localparam int RD_W  = 5;
    localparam int LAT_W = 8;

    logic             clk = 1'b0;
    logic             rst_n, i_valid, flush, div_o_valid, o_ready;
    logic             i_ready, div_i_valid, div_o_ready, o_valid, busy;
    logic [31:0]      i_rs1, i_rs2, div_wdat, div_rs1, div_rs2, o_wdat;
    logic [RD_W-1:0]  i_rd, o_rd;
    logic [4:0]       o_fflags;
    logic [LAT_W-1:0] o_lat;

    int          n_checks = 0;
    int          n_errors = 0;
    int          dly = 2;
    logic [31:0] res = 32'h0;
    bit          inject = 1'b0;

    e203_exu_fpu_fdiv_ctrl #(.RD_W(RD_W), .LAT_W(LAT_W)) dut (
        .clk(clk), .rst_n(rst_n), .i_valid(i_valid), .i_ready(i_ready),
        .i_rs1(i_rs1), .i_rs2(i_rs2), .i_rd(i_rd), .flush(flush),
        .div_i_valid(div_i_valid), .div_rs1(div_rs1), .div_rs2(div_rs2),
        .div_o_valid(div_o_valid), .div_o_ready(div_o_ready), .div_wdat(div_wdat),
        .o_valid(o_valid), .o_ready(o_ready), .o_wdat(o_wdat), .o_rd(o_rd),
        .o_fflags(o_fflags), .o_lat(o_lat), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] ref_wdat(input logic [31:0] r);
        return (r[30:23] == 8'hFF && r[22:0] != 0) ? 32'h7FC0_0000 : r;
    endfunction

    function automatic logic [4:0] ref_flags(input logic [31:0] a, input logic [31:0] b, input logic [31:0] r);
        bit a_fin, b_fin, a_zero, b_zero, a_inf, b_inf, a_snan, b_snan, r_inf, nv, dz, of, uf;
        a_fin  = a[30:23] != 8'hFF;
        b_fin  = b[30:23] != 8'hFF;
        a_zero = a[30:0] == 0;
        b_zero = b[30:0] == 0;
        a_inf  = a[30:0] == 31'h7F80_0000;
        b_inf  = b[30:0] == 31'h7F80_0000;
        a_snan = !a_fin && a[22:0] != 0 && !a[22];
        b_snan = !b_fin && b[22:0] != 0 && !b[22];
        r_inf  = r[30:0] == 31'h7F80_0000;
        nv = a_snan || b_snan || (a_inf && b_inf) || (a_zero && b_zero);
        dz = b_zero && a_fin && !a_zero;
        of = r_inf && a_fin && b_fin && !b_zero;
        uf = r[30:23] == 0 && a_fin && !a_zero && b_fin;
        if (nv || dz) return {nv, dz, 3'b000};
        return {2'b00, of, uf, of || uf};
    endfunction

    function automatic logic [31:0] pick_fp();
        logic [31:0] s;
        s = {$urandom_range(0, 1) == 1, 31'h0};
        case ($urandom_range(0, 7))
            0: return s;
            1: return s | 32'h7F80_0000;
            2: return s | 32'h7FC0_0000 | $urandom_range(0, 32'h3F_FFFF);
            3: return s | 32'h7F80_0000 | $urandom_range(1, 32'h3F_FFFF);
            4: return s | $urandom_range(1, 32'h7F_FFFF);
            5: return s | 32'h7F7F_FFFF;
            default: return $urandom;
        endcase
    endfunction

    // Divider stub: pulses the result after dly cycles of a held request.
    initial begin
        int k;
        k = 0;
        div_o_valid = 1'b0;
        div_wdat = 32'h0;
        forever begin
            @(posedge clk);
            #2;
            div_o_valid = 1'b0;
            if (div_i_valid) begin
                k++;
                if (k == dly) begin
                    div_o_valid = 1'b1;
                    div_wdat = res;
                end
            end else begin
                k = 0;
            end
            if (inject) begin
                div_o_valid = 1'b1;
                div_wdat = $urandom;
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_i_ready"}, i_ready, 0);
        check({tag, "_o_valid"}, o_valid, 0);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_div_i_valid"}, div_i_valid, 0);
        check({tag, "_div_o_ready"}, div_o_ready, 0);
        check({tag, "_o_wdat"}, o_wdat, 0);
        check({tag, "_o_rd"}, o_rd, 0);
        check({tag, "_o_fflags"}, o_fflags, 0);
        check({tag, "_o_lat"}, o_lat, 0);
        check({tag, "_div_rs1"}, div_rs1, 0);
        check({tag, "_div_rs2"}, div_rs2, 0);
    endtask

    task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic [RD_W-1:0] rd,
                         input logic [31:0] r, input int d);
        int n;
        res = r;
        dly = d;
        i_rs1 = a;
        i_rs2 = b;
        i_rd = rd;
        i_valid = 1'b1;
        n = 0;
        while (!i_ready && n < 1000) begin
            tick();
            n++;
        end
        check("accept", i_ready, 1);
        tick();
        i_valid = 1'b0;
    endtask

    task automatic wait_resp(input logic [31:0] a, input logic [31:0] b, input logic [RD_W-1:0] rd,
                             input logic [31:0] r, input int d);
        int n;
        n = 0;
        while (!o_valid && n < 600) begin
            if (div_i_valid) begin
                check("div_rs1", div_rs1, a);
                check("div_rs2", div_rs2, b);
            end
            tick();
            n++;
        end
        check("resp_valid", o_valid, 1);
        check("o_wdat", o_wdat, ref_wdat(r));
        check("o_rd", o_rd, rd);
        check("o_fflags", o_fflags, ref_flags(a, b, r));
        check("o_lat", o_lat, d > 255 ? 255 : d);
    endtask

    task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic [RD_W-1:0] rd,
                          input logic [31:0] r, input int d);
        o_ready = 1'b1;
        issue(a, b, rd, r, d);
        wait_resp(a, b, rd, r, d);
        tick();
        check("single_cycle_ovalid", o_valid, 0);
    endtask

    initial begin
        int n, h, d;
        logic [31:0] a, b, r;
        logic [RD_W-1:0] rd;
        rst_n = 1'b1; i_valid = 1'b0; flush = 1'b0; o_ready = 1'b0;
        i_rs1 = 32'h0; i_rs2 = 32'h0; i_rd = '0;
        #1 rst_n = 1'b0;
        #2 check_zero("reset");
        tick(); tick();
        rst_n = 1'b1;
        check("boot_irdy", i_ready, 0);
        tick();
        check("drain_busy", busy, 1);
        check("drain_div_valid", div_i_valid, 0);
        check("drain_irdy", i_ready, 0);
        tick();
        check("idle_irdy", i_ready, 1);
        check("idle_busy", busy, 0);

        run_op(32'h40C0_0000, 32'h4040_0000, 5'd7, 32'h4000_0000, 3);
        run_op(32'h3F80_0000, 32'h0000_0000, 5'd8, 32'h7F80_0000, 4);
        run_op(32'h0000_0000, 32'h0000_0000, 5'd9, 32'hFFC0_0000, 2);
        run_op(32'h7F00_0000, 32'h3E80_0000, 5'd10, 32'h7F80_0000, 5);

        // back-to-back with writeback stalled
        o_ready = 1'b0;
        issue(32'h40C0_0000, 32'h4040_0000, 5'd3, 32'h4000_0000, 3);
        wait_resp(32'h40C0_0000, 32'h4040_0000, 5'd3, 32'h4000_0000, 3);
        res = 32'h3F00_0000;
        dly = 4;
        i_rs1 = 32'h3F80_0000; i_rs2 = 32'h4000_0000; i_rd = 5'd21; i_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            check("stall_ovalid", o_valid, 1);
            check("stall_wdat", o_wdat, 32'h4000_0000);
            check("stall_rd", o_rd, 3);
            check("stall_irdy", i_ready, 0);
            tick();
        end
        o_ready = 1'b1;
        #1 check("bypass_irdy", i_ready, 1);
        tick();
        i_valid = 1'b0;
        o_ready = 1'b0;
        check("bypass_ovalid", o_valid, 0);
        check("bypass_busy", busy, 1);
        wait_resp(32'h3F80_0000, 32'h4000_0000, 5'd21, 32'h3F00_0000, 4);
        o_ready = 1'b1;
        tick();

        // flush three cycles after accept
        issue(32'h40C0_0000, 32'h4040_0000, 5'd12, 32'h4000_0000, 8);
        n = 0;
        while (busy && n < 50) begin
            flush = n == 2;
            check("flush_ovalid", o_valid, 0);
            check("flush_irdy", i_ready, 0);
            tick();
            n++;
        end
        flush = 1'b0;
        check("flush_busy_cycles", n, 8);
        check("flush_ovalid_after", o_valid, 0);
        run_op(32'h40C0_0000, 32'h4040_0000, 5'd13, 32'h4000_0000, 3);

        // reset mid-issue
        issue(32'h40C0_0000, 32'h4040_0000, 5'd14, 32'h4000_0000, 10);
        tick(); tick();
        #2 rst_n = 1'b0;
        #1 check_zero("async_reset");
        tick();
        rst_n = 1'b1;
        check("rel_irdy", i_ready, 0);
        tick();
        check("rel_drain_busy", busy, 1);
        check("rel_drain_divv", div_i_valid, 0);
        inject = 1'b1;
        tick(); tick();
        inject = 1'b0;
        check("stray_pulse_busy", busy, 0);
        check("stray_pulse_ovalid", o_valid, 0);
        run_op(32'h40C0_0000, 32'h4040_0000, 5'd15, 32'h4000_0000, 3);

        run_op(32'h40C0_0000, 32'h4040_0000, 5'd16, 32'h4000_0000, 300);

        for (int i = 0; i < 40; i++) begin
            a = pick_fp(); b = pick_fp(); r = pick_fp();
            rd = RD_W'($urandom);
            d = $urandom_range(2, 6);
            h = $urandom_range(0, 3);
            o_ready = 1'b0;
            issue(a, b, rd, r, d);
            wait_resp(a, b, rd, r, d);
            for (int j = 0; j < h; j++) begin
                tick();
                check("rnd_hold_valid", o_valid, 1);
                check("rnd_hold_wdat", o_wdat, ref_wdat(r));
            end
            o_ready = 1'b1;
            tick();
            o_ready = 1'b0;
            check("rnd_release", o_valid, 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/e203_exu_fpu_fdiv_ctrl.md
# e203_exu_fpu_fdiv_ctrl

Issue/writeback controller for the single-precision FP divider in the E203 FPU. It accepts FDIV.S requests from FPU dispatch and drives the divider's hold-until-done handshake with stable operands. It also captures the divider's one-cycle result pulse, canonicalises NaNs, and generates RISC-V fflags. The result and destination tag are held in a skid register until the writeback arbiter accepts them.

## Interface
- RD_W, 5, destination register index width
- LAT_W, 8, width of saturating latency counter
- clk  in  1  clock, all state on rising edge
- rst_n  in  1  asynchronous active-low reset
- i_valid  in  1  dispatch request valid
- i_ready  out  1  request accepted when i_valid & i_ready
- i_rs1 / i_rs2  in  32  dividend / divisor (IEEE-754 single)
- i_rd  in  RD_W  destination tag
- flush  in  1  pipeline flush; discards in-flight op
- div_i_valid  out  1  to divider request valid; held until result
- div_rs1 / div_rs2  out  32  registered operands to divider
- div_o_valid  in  1  divider result pulse
- div_o_ready  out  1  to divider; high in ISSUE
- div_wdat  in  32  divider result
- o_valid  out  1  writeback valid
- o_ready  in  1  writeback accept
- o_wdat  out  32  result
- o_rd  out  RD_W  destination tag
- o_fflags  out  5  {NV,DZ,OF,UF,NX}
- o_lat  out  LAT_W  cycles spent in ISSUE for this result, saturating
- busy  out  1  state != IDLE

## Operation
- States: IDLE, ISSUE, DRAIN, RESP. Reset → IDLE; all outputs 0, operand/result registers 0.
- IDLE: i_ready=1. On accept, register rs1/rs2/rd, classify operands, clear lat counter → ISSUE.
- ISSUE: div_i_valid=1, div_o_ready=1, lat counter increments, saturating at all-ones. div_rs1/div_rs2 stay constant. On div_o_valid: capture div_wdat → RESP. If flush is seen in the same cycle as or before div_o_valid, go to IDLE instead and drop the result.
- Flush in ISSUE before the result sets a discard flag and stays in ISSUE. The divider has no abort, so the block keeps waiting for the result pulse. When the pulse arrives the result is dropped → IDLE. i_ready=0 throughout.
- DRAIN: not used in the normal flow. It is entered for one cycle after reset deasserts, with div_i_valid=0. This guarantees the divider sees an invalid request before the first issue.
- RESP: o_valid=1. Outputs are stable until o_ready. On o_ready: i_ready=o_ready in RESP (bypass). A same-cycle accept goes directly to ISSUE; otherwise → IDLE. Flush in RESP drops o_valid → IDLE.
- div_i_valid deasserts in the cycle after div_o_valid. It is never high in IDLE or RESP.
- NaN canonicalisation: if captured exponent == 0xFF and mantissa != 0, o_wdat = 0x7FC00000.
- fflags, from operand class registered at accept:
  - NV: either operand is sNaN, or inf/inf, or 0/0.
  - DZ: b is ±0 and a is finite and nonzero.
  - OF: result is ±inf and both operands are finite and b is nonzero.
  - UF: result exponent is 0 and a is finite and nonzero and b is finite.
  - NX = OF | UF.
  - NV and DZ force OF, UF and NX to 0.

## Timing
- Accept at cycle T; div_i_valid=1 from T+1.
- Result pulse at cycle R (R ≥ T+2); o_valid=1 from R+1.
- Divider turnaround is fixed by the divider. The controller adds 1 cycle at the input and 1 cycle at the output.
- o_lat = R − T, saturating.
- With o_ready held high, RESP lasts 1 cycle and the next request is accepted in that same cycle.
- Reset is asynchronous. Asserting it mid-ISSUE clears all state immediately, and DRAIN follows the release. A result pulse arriving during DRAIN or IDLE is ignored.

## Test plan
- 0x40C00000 / 0x40400000 (6/3), o_ready=1 → o_wdat=0x40000000, o_fflags=0, o_rd=tag, o_valid for 1 cycle.
- 0x3F800000 / 0x00000000 → o_wdat=0x7F800000, o_fflags=5'b01000. Then 0x00000000 / 0x00000000 → o_wdat=0x7FC00000 (divider output 0xFFC00000 rewritten), o_fflags=5'b10000.
- 0x7F000000 / 0x3E800000 (overflow) → o_wdat=0x7F800000, o_fflags=5'b00101.
- Two back-to-back requests with o_ready low for 10 cycles after the first result:
  - the first result holds stable;
  - i_ready stays 0;
  - the second request is accepted in the o_ready cycle and completes with the correct tag.
- Flush 3 cycles after accept → o_valid never rises for that op, busy stays 1 until the result pulse, then IDLE; the next op yields the correct result.
- rst_n low mid-ISSUE → all outputs 0 asynchronously; after release there is 1 DRAIN cycle, and the next 6/3 request returns 0x40000000.
